proc_memory: RTL

Memory-side partner of the 8-bit processor core: owns instruction memory (IM) and data memory (DM) and serves the core's fetch, load and store traffic. It boot-loads the program into IM over a byte-stream port and releases the core through `proc_en`. When the core raises `finish`, it streams a window of DM back out over a byte-stream handshake. It sits beside the processor at the top level, with its memory outputs wired directly to the core's memory inputs.

---
 rtl/proc_mem_pkg.sv | 17 +
 rtl/proc_memory_if.sv | 35 +++
 rtl/proc_memory_byte_ram.sv | 28 ++
 rtl/proc_memory.sv | 125 ++++++++++++
 4 files changed

// File: rtl/proc_mem_pkg.sv
// Shared types and sizing helpers for the processor-side memory block.
package proc_mem_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} state_e;

   // Depths are powers of two; a floor of one bit keeps tiny memories addressable.
   function automatic int im_aw(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic int dm_aw(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/proc_memory_if.sv
// Load, core-memory and dump signals between proc_memory and its neighbours.
interface proc_memory_if;
   import proc_mem_pkg::*;

   logic              load_valid;
   logic [BYTE_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              proc_en;
   logic [7:0]        im_addr;
   logic [BYTE_W-1:0] im_data;
   logic              d_write;
   logic [15:0]       dm_write;
   logic [BYTE_W-1:0] dm_val;
   logic [BYTE_W-1:0] dm_data;
   logic              finish;
   logic              dump_valid;
   logic [BYTE_W-1:0] dump_data;
   logic              dump_last;
   logic              dump_ready;
   logic              done;

   modport master (
      output load_valid, load_data, load_last, im_addr, d_write, dm_write, dm_val,
             finish, dump_ready,
      input  load_ready, proc_en, im_data, dm_data, dump_valid, dump_data, dump_last, done
   );

   modport slave (
      input  load_valid, load_data, load_last, im_addr, d_write, dm_write, dm_val,
             finish, dump_ready,
      output load_ready, proc_en, im_data, dm_data, dump_valid, dump_data, dump_last, done
   );

endinterface

// File: rtl/proc_memory_byte_ram.sv
// Byte-wide RAM: one synchronous write port, NRD combinational read ports.
module byte_ram
   import proc_mem_pkg::*;
#(
   parameter int  DEPTH = 256,
   parameter int  NRD   = 2,
   localparam int AW    = im_aw(DEPTH)
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [AW-1:0]               waddr,
   input  logic [BYTE_W-1:0]           wdata,
   input  logic [NRD-1:0][AW-1:0]      raddr,
   output logic [NRD-1:0][BYTE_W-1:0]  rdata
);

   // Contents are deliberately not reset so DM survives a core restart.
   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rdata[i] = mem[raddr[i]];
   end

endmodule

// File: rtl/proc_memory.sv
// Boot-loads IM, serves core fetch/load/store, then streams a DM window out.
module proc_memory
   import proc_mem_pkg::*;
#(
   parameter int IM_DEPTH  = 256,
   parameter int DM_DEPTH  = 256,
   parameter int DUMP_BASE = 0,
   parameter int DUMP_LEN  = 16
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   proc_memory_if.slave  bus
);

   localparam int IAW = im_aw(IM_DEPTH);
   localparam int DAW = dm_aw(DM_DEPTH);
   localparam logic [IAW-1:0] LPTR_MAX  = IAW'(IM_DEPTH - 1);
   localparam logic [DAW-1:0] DPTR_LAST = DAW'(DUMP_LEN - 1);
   localparam logic [DAW-1:0] DBASE     = DAW'(DUMP_BASE);

   state_e            state_q, state_d;
   logic [IAW-1:0]    lptr_q, lptr_d;
   logic [DAW-1:0]    dptr_q, dptr_d;
   logic              dump_valid_q, dump_valid_d;
   logic              dump_last_q, dump_last_d;
   logic [BYTE_W-1:0] dump_data_q, dump_data_d;

   logic              load_acc, dm_we, dump_xfer;
   logic [DAW-1:0]    dump_idx;
   logic [BYTE_W-1:0] im_rd, dm_rd, dump_rd;
   logic              unused_dm_hi;

   assign load_acc  = bus.load_valid && (state_q == LOAD);
   assign dm_we     = bus.d_write && (state_q == RUN);
   assign dump_xfer = dump_valid_q && bus.dump_ready;
   // Before the first byte is presented, fetch dptr itself; afterwards prefetch the next one.
   assign dump_idx  = dump_valid_q ? dptr_q + 1'b1 : dptr_q;
   assign unused_dm_hi = ^bus.dm_write[15:DAW];

   byte_ram #(.DEPTH(IM_DEPTH), .NRD(1)) u_im (
      .clk   (CLOCK),
      .we    (load_acc),
      .waddr (lptr_q),
      .wdata (bus.load_data),
      .raddr (bus.im_addr[IAW-1:0]),
      .rdata (im_rd)
   );

   byte_ram #(.DEPTH(DM_DEPTH), .NRD(2)) u_dm (
      .clk   (CLOCK),
      .we    (dm_we),
      .waddr (bus.dm_write[DAW-1:0]),
      .wdata (bus.dm_val),
      .raddr ({DBASE + dump_idx, bus.dm_write[DAW-1:0]}),
      .rdata ({dump_rd, dm_rd})
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) state_q <= LOAD;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (load_acc && (bus.load_last || lptr_q == LPTR_MAX)) state_d = RUN;
         RUN:     if (bus.finish) state_d = DUMP;
         DUMP:    if (dump_xfer && dump_last_q) state_d = DONE;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      bus.load_ready = (state_q == LOAD);
      bus.proc_en    = (state_q == RUN);
      bus.done       = (state_q == DONE);
      bus.im_data    = im_rd;
      bus.dm_data    = dm_rd;
      bus.dump_valid = dump_valid_q;
      bus.dump_data  = dump_data_q;
      bus.dump_last  = dump_last_q;
   end

   always_comb begin
      lptr_d       = lptr_q;
      dptr_d       = dptr_q;
      dump_valid_d = dump_valid_q;
      dump_last_d  = dump_last_q;
      dump_data_d  = dump_data_q;
      if (load_acc) lptr_d = lptr_q + 1'b1;
      if (state_q == DUMP) begin
         if (!dump_valid_q) begin
            dump_valid_d = 1'b1;
            dump_data_d  = dump_rd;
            dump_last_d  = (dptr_q == DPTR_LAST);
         end else if (dump_xfer) begin
            if (dump_last_q) begin
               dump_valid_d = 1'b0;
               dump_last_d  = 1'b0;
            end else begin
               dptr_d      = dump_idx;
               dump_data_d = dump_rd;
               dump_last_d = (dump_idx == DPTR_LAST);
            end
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         lptr_q       <= '0;
         dptr_q       <= '0;
         dump_valid_q <= 1'b0;
         dump_last_q  <= 1'b0;
         dump_data_q  <= '0;
      end else begin
         lptr_q       <= lptr_d;
         dptr_q       <= dptr_d;
         dump_valid_q <= dump_valid_d;
         dump_last_q  <= dump_last_d;
         dump_data_q  <= dump_data_d;
      end
   end

endmodule
